// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: ALU control
// encodings and the sequencer state type.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_alu.sv
// Existing combinational ALU: AND/OR/ADD/SUB selected by control, plus a
// zero flag on the result.
module alu_mul_sequencer_alu
  import alu_mul_sequencer_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [3:0]   control,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         zero
);

  logic [N-1:0] result_s;

  // operation select; unknown encodings yield zero
  always_comb begin
    result_s = '0;
    case (control)
      ALU_AND: result_s = a & b;
      ALU_OR:  result_s = a | b;
      ALU_ADD: result_s = a + b;
      ALU_SUB: result_s = a - b;
      default: result_s = '0;
    endcase
  end

  assign result = result_s;
  assign zero   = (result_s == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle N-bit multiplier: sequences the shared ALU in ADD mode over a
// shift-add loop and returns the low N bits of a*b with a start/busy/done handshake.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int N          = 64,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic         product_zero
);

  localparam int            CW     = $clog2(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  seq_state_t    state_r;
  logic [N-1:0]  mcand_r;
  logic [N-1:0]  mplier_r;
  logic [N-1:0]  acc_r;
  logic [CW-1:0] count_r;
  logic          busy_r;
  logic          done_r;
  logic [N-1:0]  product_r;
  logic          product_zero_r;

  logic [N-1:0]  alu_result_s;
  logic [N-1:0]  acc_next_s;
  logic [N-1:0]  mplier_next_s;
  logic          last_s;

  // The zero flag is not needed: product_zero comes from the registered result.
  alu_mul_sequencer_alu #(.N(N)) u_alu (
    .control (ALU_ADD),
    .a       (acc_r),
    .b       (mcand_r),
    .result  (alu_result_s),
    .zero    ()
  );

  // next accumulator / multiplier and loop-exit decision for the current RUN cycle
  always_comb begin
    acc_next_s    = acc_r;
    mplier_next_s = mplier_r >> 1;
    last_s        = 1'b0;
    if (mplier_r[0]) begin
      acc_next_s = alu_result_s;
    end else begin
      acc_next_s = acc_r;
    end
    if (count_r == LAST_C) begin
      last_s = 1'b1;
    end else if ((EARLY_EXIT == 1'b1) && (mplier_next_s == '0)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // sequencer FSM, datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      mcand_r        <= '0;
      mplier_r       <= '0;
      acc_r          <= '0;
      count_r        <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      product_r      <= '0;
      product_zero_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
            count_r  <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_next_s;
          count_r  <= count_r + ONE_C;
          // result is published on the exit edge so it is valid alongside done
          if (last_s) begin
            product_r      <= acc_next_s;
            product_zero_r <= (acc_next_s == '0);
            done_r         <= 1'b1;
            state_r        <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign product      = product_r;
  assign product_zero = product_zero_r;

endmodule
